// File: rtl/load_data_unit_pkg.sv
// Shared types for the load data unit: memory op encoding, FSM states, alignment helper.
package CorePack;

  typedef enum logic [2:0] {
    MEM_NO = 3'd0,
    MEM_B  = 3'd1,
    MEM_H  = 3'd2,
    MEM_W  = 3'd3,
    MEM_D  = 3'd4,
    MEM_UB = 3'd5,
    MEM_UH = 3'd6,
    MEM_UW = 3'd7
  } mem_op_enum;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } load_state_t;

  // True when the access is not naturally aligned for its size.
  function automatic logic is_misaligned(input mem_op_enum op, input logic [2:0] off);
    case (op)
      MEM_H, MEM_UH: return off[0];
      MEM_W, MEM_UW: return |off[1:0];
      MEM_D:         return |off;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_data_unit_if.sv
// Load request/response and data-memory read bus; ld_misalign exists only with LOAD_MISALIGN_CHECK_EN.
interface load_data_unit_if
  import CorePack::*;
#(
  parameter int ADDR_WIDTH = 64
);
  logic                  ld_req_valid;
  logic                  ld_req_ready;
  logic [ADDR_WIDTH-1:0] ld_addr;
  mem_op_enum            ld_op;
  logic                  mem_rd_req_valid;
  logic                  mem_rd_req_ready;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic                  mem_rd_resp_valid;
  logic [63:0]           mem_rd_resp_data;
  logic                  ld_resp_valid;
  logic [63:0]           ld_resp_data;
`ifdef LOAD_MISALIGN_CHECK_EN
  logic                  ld_misalign;

  modport master (
    output ld_req_valid, ld_addr, ld_op, mem_rd_req_ready, mem_rd_resp_valid, mem_rd_resp_data,
    input  ld_req_ready, mem_rd_req_valid, mem_rd_addr, ld_resp_valid, ld_resp_data, ld_misalign
  );
  modport slave (
    input  ld_req_valid, ld_addr, ld_op, mem_rd_req_ready, mem_rd_resp_valid, mem_rd_resp_data,
    output ld_req_ready, mem_rd_req_valid, mem_rd_addr, ld_resp_valid, ld_resp_data, ld_misalign
  );
`else
  modport master (
    output ld_req_valid, ld_addr, ld_op, mem_rd_req_ready, mem_rd_resp_valid, mem_rd_resp_data,
    input  ld_req_ready, mem_rd_req_valid, mem_rd_addr, ld_resp_valid, ld_resp_data
  );
  modport slave (
    input  ld_req_valid, ld_addr, ld_op, mem_rd_req_ready, mem_rd_resp_valid, mem_rd_resp_data,
    output ld_req_ready, mem_rd_req_valid, mem_rd_addr, ld_resp_valid, ld_resp_data
  );
`endif
endinterface

// File: rtl/load_data_unit_data_trunc.sv
// Combinational lane select plus sign/zero extension of a 64-bit memory doubleword.
module data_trunc
  import CorePack::*;
(
  input  logic [63:0] data,
  input  logic [2:0]  offset,
  input  mem_op_enum  op,
  output logic [63:0] result
);
  logic [7:0]  byte_lane [8];
  logic [15:0] half_lane [4];
  logic [31:0] word_lane [2];

  for (genvar gi = 0; gi < 8; gi++) begin : g_byte
    assign byte_lane[gi] = data[gi*8 +: 8];
  end
  for (genvar gi = 0; gi < 4; gi++) begin : g_half
    assign half_lane[gi] = data[gi*16 +: 16];
  end
  for (genvar gi = 0; gi < 2; gi++) begin : g_word
    assign word_lane[gi] = data[gi*32 +: 32];
  end

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] word_sel;

  // Unused low bits drop out here: halfwords ignore offset[0], words ignore offset[1:0].
  assign byte_sel = byte_lane[offset];
  assign half_sel = half_lane[offset[2:1]];
  assign word_sel = word_lane[offset[2]];

  always_comb begin
    result = '0;
    case (op)
      MEM_B:   result = {{56{byte_sel[7]}}, byte_sel};
      MEM_UB:  result = {56'd0, byte_sel};
      MEM_H:   result = {{48{half_sel[15]}}, half_sel};
      MEM_UH:  result = {48'd0, half_sel};
      MEM_W:   result = {{32{word_sel[31]}}, word_sel};
      MEM_UW:  result = {32'd0, word_sel};
      MEM_D:   result = data;
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/load_data_unit.sv
// Load data unit: accepts a load, issues an aligned doubleword read, returns the extracted result.
// Optional misaligned-load trap when LOAD_MISALIGN_CHECK_EN is defined.
module load_data_unit
  import CorePack::*;
#(
  parameter int ADDR_WIDTH = 64
)(
  input  logic             clk,
  input  logic             rst,
  load_data_unit_if.slave  bus
);
  load_state_t           state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  mem_op_enum            op_reg, op_next;
  logic [63:0]           result_reg, result_next;
  logic [63:0]           trunc_result;
`ifdef LOAD_MISALIGN_CHECK_EN
  logic                  misalign_reg, misalign_next;
`endif

  data_trunc u_data_trunc (
    .data   (bus.mem_rd_resp_data),
    .offset (addr_reg[2:0]),
    .op     (op_reg),
    .result (trunc_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg     <= '0;
      op_reg       <= MEM_NO;
      result_reg   <= '0;
`ifdef LOAD_MISALIGN_CHECK_EN
      misalign_reg <= 1'b0;
`endif
    end else begin
      addr_reg     <= addr_next;
      op_reg       <= op_next;
      result_reg   <= result_next;
`ifdef LOAD_MISALIGN_CHECK_EN
      misalign_reg <= misalign_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    op_next       = op_reg;
    result_next   = result_reg;
`ifdef LOAD_MISALIGN_CHECK_EN
    misalign_next = misalign_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.ld_req_valid && bus.ld_op != MEM_NO) begin
          addr_next  = bus.ld_addr;
          op_next    = bus.ld_op;
          state_next = REQ;
`ifdef LOAD_MISALIGN_CHECK_EN
          misalign_next = 1'b0;
          // Misaligned loads skip memory entirely and report a zero result.
          if (is_misaligned(bus.ld_op, bus.ld_addr[2:0])) begin
            misalign_next = 1'b1;
            result_next   = '0;
            state_next    = DONE;
          end
`endif
        end
      end
      REQ: begin
        if (bus.mem_rd_req_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_rd_resp_valid) begin
          result_next = trunc_result;
          state_next  = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.ld_req_ready     = (state_reg == IDLE);
  assign bus.mem_rd_req_valid = (state_reg == REQ);
  assign bus.mem_rd_addr      = {addr_reg[ADDR_WIDTH-1:3], 3'b000};
  assign bus.ld_resp_valid    = (state_reg == DONE);
  assign bus.ld_resp_data     = result_reg;
`ifdef LOAD_MISALIGN_CHECK_EN
  assign bus.ld_misalign      = (state_reg == DONE) && misalign_reg;
`endif
endmodule

// File: tb/tb_load_data_unit.sv
// Scoreboard bench for load_data_unit: directed loads, backpressure, stray response, reset abort, misalignment.
module tb_load_data_unit;
  import CorePack::*;

  localparam logic [63:0] RDATA = 64'hF1E2D3C4B5A69788;

  typedef struct {
    logic [63:0] data;
    logic        mis;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_data_unit_if #(.ADDR_WIDTH(64)) bus ();

  load_data_unit #(.ADDR_WIDTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (bus.ld_resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_resp: got ld_resp_valid=1 data %h expected no response", bus.ld_resp_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_data"}, bus.ld_resp_data, e.data);
`ifdef LOAD_MISALIGN_CHECK_EN
        chk({e.name, "_misalign"}, {63'd0, bus.ld_misalign}, {63'd0, e.mis});
`endif
        $display("resp %s data=%h", e.name, bus.ld_resp_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full load transaction; stall = cycles mem_rd_req_ready is held low in REQ.
  task automatic do_load(input string name, input logic [63:0] addr, input mem_op_enum op,
                         input logic [63:0] exp, input int stall);
    exp_t e;
    logic [63:0] req_addr;
    e.data = exp;
    e.mis  = 1'b0;
    e.name = name;
    sb.push_back(e);
    chk({name, "_ready"}, {63'd0, bus.ld_req_ready}, 64'd1);
    bus.ld_req_valid = 1'b1;
    bus.ld_addr      = addr;
    bus.ld_op        = op;
    step();
    bus.ld_req_valid = 1'b0;
    bus.ld_op        = MEM_NO;
    bus.ld_addr      = '0;
    chk({name, "_req_valid"}, {63'd0, bus.mem_rd_req_valid}, 64'd1);
    chk({name, "_rd_addr"}, bus.mem_rd_addr, {addr[63:3], 3'b000});
    req_addr = bus.mem_rd_addr;
    for (int i = 0; i < stall; i++) begin
      step();
      chk({name, "_stall_valid"}, {63'd0, bus.mem_rd_req_valid}, 64'd1);
      chk({name, "_stall_addr"}, bus.mem_rd_addr, req_addr);
    end
    bus.mem_rd_req_ready = 1'b1;
    step();
    bus.mem_rd_req_ready = 1'b0;
    bus.mem_rd_resp_valid = 1'b1;
    bus.mem_rd_resp_data  = RDATA;
    step();
    bus.mem_rd_resp_valid = 1'b0;
    bus.mem_rd_resp_data  = '0;
    chk({name, "_latency"}, {63'd0, bus.ld_resp_valid}, 64'd1);
    step();
    chk({name, "_pulse"}, {63'd0, bus.ld_resp_valid}, 64'd0);
    chk({name, "_hold"}, bus.ld_resp_data, exp);
    $display("load %s addr=%h op=%s stall=%0d", name, addr, op.name(), stall);
  endtask

  initial begin
    bus.ld_req_valid      = 1'b0;
    bus.ld_addr           = '0;
    bus.ld_op             = MEM_NO;
    bus.mem_rd_req_ready  = 1'b0;
    bus.mem_rd_resp_valid = 1'b0;
    bus.mem_rd_resp_data  = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_ready", {63'd0, bus.ld_req_ready}, 64'd1);
    chk("rst_req_valid", {63'd0, bus.mem_rd_req_valid}, 64'd0);
    chk("rst_resp_valid", {63'd0, bus.ld_resp_valid}, 64'd0);
    chk("rst_resp_data", bus.ld_resp_data, 64'd0);
`ifdef LOAD_MISALIGN_CHECK_EN
    chk("rst_misalign", {63'd0, bus.ld_misalign}, 64'd0);
`endif

    do_load("lb",  64'h1003, MEM_B,  64'hFFFFFFFFFFFFFFB5, 0);
    do_load("lbu", 64'h1003, MEM_UB, 64'h00000000000000B5, 0);
    do_load("lh",  64'h1006, MEM_H,  64'hFFFFFFFFFFFFF1E2, 0);
    do_load("lhu", 64'h1006, MEM_UH, 64'h000000000000F1E2, 0);
    do_load("ld",  64'h1000, MEM_D,  64'hF1E2D3C4B5A69788, 0);
    do_load("lw",  64'h1004, MEM_W,  64'hFFFFFFFFF1E2D3C4, 0);
    do_load("lwu", 64'h1000, MEM_UW, 64'h00000000B5A69788, 0);
    do_load("lw_bp", 64'h2004, MEM_W, 64'hFFFFFFFFF1E2D3C4, 3);

    // MEM_NO is not a load and must leave the block idle.
    bus.ld_req_valid = 1'b1;
    bus.ld_addr      = 64'h3000;
    bus.ld_op        = MEM_NO;
    step();
    step();
    bus.ld_req_valid = 1'b0;
    chk("memno_ready", {63'd0, bus.ld_req_ready}, 64'd1);
    chk("memno_req_valid", {63'd0, bus.mem_rd_req_valid}, 64'd0);
    $display("memno ignored");

    // Stray response while idle.
    bus.mem_rd_resp_valid = 1'b1;
    bus.mem_rd_resp_data  = RDATA;
    step();
    bus.mem_rd_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stray_resp_valid", {63'd0, bus.ld_resp_valid}, 64'd0);
      step();
    end
    $display("stray response ignored");

    // Reset during WAIT aborts the load.
    bus.ld_req_valid = 1'b1;
    bus.ld_addr      = 64'h1000;
    bus.ld_op        = MEM_D;
    step();
    bus.ld_req_valid = 1'b0;
    bus.ld_op        = MEM_NO;
    bus.mem_rd_req_ready = 1'b1;
    step();
    bus.mem_rd_req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstwait_ready", {63'd0, bus.ld_req_ready}, 64'd1);
    chk("rstwait_data", bus.ld_resp_data, 64'd0);
    bus.mem_rd_resp_valid = 1'b1;
    bus.mem_rd_resp_data  = RDATA;
    step();
    bus.mem_rd_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rstwait_resp_valid", {63'd0, bus.ld_resp_valid}, 64'd0);
      step();
    end
    $display("reset in WAIT aborted load");

`ifdef LOAD_MISALIGN_CHECK_EN
    begin
      exp_t e;
      e.data = 64'd0;
      e.mis  = 1'b1;
      e.name = "lw_mis";
      sb.push_back(e);
      bus.ld_req_valid = 1'b1;
      bus.ld_addr      = 64'h1002;
      bus.ld_op        = MEM_W;
      step();
      bus.ld_req_valid = 1'b0;
      bus.ld_op        = MEM_NO;
      chk("lw_mis_no_req", {63'd0, bus.mem_rd_req_valid}, 64'd0);
      chk("lw_mis_resp_valid", {63'd0, bus.ld_resp_valid}, 64'd1);
      step();
      chk("lw_mis_pulse", {63'd0, bus.ld_resp_valid}, 64'd0);
      chk("lw_mis_no_req2", {63'd0, bus.mem_rd_req_valid}, 64'd0);
      $display("load lw_mis addr=0000000000001002 trapped");
    end
`else
    do_load("lw_mis", 64'h1002, MEM_W, 64'hFFFFFFFFB5A69788, 0);
`endif

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
